btn_input_stage: RTL and testbench

- Front-end conditioning stage for the three player buttons (left, right, jump). It sits directly upstream of the character/physics logic and the button debug counters.
- Per button: synchronise the raw pad input, debounce it, and produce a clean level plus one-cycle rise pulses.
- Adds a jump-charge tracker that counts character ticks while jump is held and reports the captured charge on release.
- Replaces the separate debounce instances and delay registers in the top level with one block.

---
 rtl/btn_input_stage_if.sv | 34 +++
 rtl/btn_input_stage.sv | 160 ++++++++++++++++
 tb/tb_btn_input_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/btn_input_stage_if.sv
// Button pad inputs, character tick and conditioned outputs of btn_input_stage.
// The stage drives results through slave; the pad/timing side uses master.
interface btn_input_stage_if #(
   parameter int unsigned CHARGE_WIDTH = 8
);
   logic                    left_btn;
   logic                    right_btn;
   logic                    jump_btn;
   logic                    tick;
   logic                    left_level;
   logic                    right_level;
   logic                    jump_level;
   logic                    left_rise;
   logic                    right_rise;
   logic                    jump_rise;
   logic [1:0]              dir;
   logic                    charge_active;
   logic [CHARGE_WIDTH-1:0] jump_charge;
   logic                    jump_release;

   modport master (
      output left_btn, right_btn, jump_btn, tick,
      input  left_level, right_level, jump_level,
      input  left_rise, right_rise, jump_rise,
      input  dir, charge_active, jump_charge, jump_release
   );

   modport slave (
      input  left_btn, right_btn, jump_btn, tick,
      output left_level, right_level, jump_level,
      output left_rise, right_rise, jump_rise,
      output dir, charge_active, jump_charge, jump_release
   );
endinterface

// File: rtl/btn_input_stage.sv
// Sync, debounce and edge-detect three buttons, plus a jump-charge tracker.
// Define BTN_AUTO_REPEAT_EN for tick-based auto-repeat of left/right rises.
module btn_input_stage #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned DB_CNT_WIDTH    = 20,
   parameter int unsigned CHARGE_WIDTH    = 8,
   parameter int unsigned CHARGE_MAX      = 60,
   parameter int unsigned REPEAT_TICKS    = 8
) (
   input logic              sys_clk,
   input logic              sys_rst_n,
   btn_input_stage_if.slave btn
);
   typedef enum logic [1:0] {IDLE, CHARGING, RELEASE} state_t;

   localparam logic [DB_CNT_WIDTH-1:0] DB_LAST =
      DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CHARGE_WIDTH-1:0] CH_MAX = CHARGE_WIDTH'(CHARGE_MAX);

   if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if ((64'd1 << DB_CNT_WIDTH) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_dbw
      $error("DB_CNT_WIDTH too narrow for DEBOUNCE_CYCLES");
   end
   if ((64'd1 << CHARGE_WIDTH) <= 64'(CHARGE_MAX)) begin : g_chk_ch
      $error("CHARGE_MAX does not fit CHARGE_WIDTH");
   end
   if (REPEAT_TICKS < 1) begin : g_chk_rep
      $error("REPEAT_TICKS must be at least 1");
   end

   logic [2:0]              raw;
   logic [2:0]              meta;
   logic [2:0]              sync;
   logic [2:0]              stab;
   logic [2:0]              stab_d;
   logic [2:0]              edge_r;
   logic [2:0]              rise;
   logic [DB_CNT_WIDTH-1:0] db_cnt [3];

   assign raw = {btn.jump_btn, btn.right_btn, btn.left_btn};

   // Bit order everywhere: 0 = left, 1 = right, 2 = jump.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         meta   <= '0;
         sync   <= '0;
         stab   <= '0;
         stab_d <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         meta   <= raw;
         sync   <= meta;
         stab_d <= stab;
         for (int i = 0; i < 3; i++) begin
            if (sync[i] == stab[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stab[i]   <= sync[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_CNT_WIDTH'(1);
            end
         end
      end
   end

   assign edge_r = stab & ~stab_d;

`ifdef BTN_AUTO_REPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

   logic [RW-1:0] rep_cnt [2];
   logic [1:0]    rep_hit;
   logic [1:0]    held;

   // Only ticks after the initial edge cycle count towards a repeat.
   assign held = stab[1:0] & stab_d[1:0];

   always_comb begin
      rep_hit = '0;
      for (int i = 0; i < 2; i++) begin
         rep_hit[i] = held[i] & btn.tick & (rep_cnt[i] == REP_LAST);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!held[i]) begin
               rep_cnt[i] <= '0;
            end else if (btn.tick) begin
               if (rep_cnt[i] == REP_LAST) rep_cnt[i] <= '0;
               else rep_cnt[i] <= rep_cnt[i] + RW'(1);
            end
         end
      end
   end

   assign rise = {edge_r[2], edge_r[1:0] | rep_hit};
`else
   assign rise = edge_r;
`endif

   state_t                  state;
   state_t                  state_nx;
   logic [CHARGE_WIDTH-1:0] charge;
   logic [CHARGE_WIDTH-1:0] charge_nx;
   logic                    release_p;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state  <= IDLE;
         charge <= '0;
      end else begin
         state  <= state_nx;
         charge <= charge_nx;
      end
   end

   // Release beats a coincident tick so the reported charge is final.
   always_comb begin
      state_nx  = state;
      charge_nx = charge;
      release_p = 1'b0;
      unique case (state)
         IDLE: begin
            if (edge_r[2]) begin
               state_nx  = CHARGING;
               charge_nx = '0;
            end
         end
         CHARGING: begin
            if (!stab[2]) begin
               state_nx  = RELEASE;
               release_p = 1'b1;
            end else if (btn.tick && (charge < CH_MAX)) begin
               charge_nx = charge + CHARGE_WIDTH'(1);
            end
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign btn.left_level    = stab[0];
   assign btn.right_level   = stab[1];
   assign btn.jump_level    = stab[2];
   assign btn.left_rise     = rise[0];
   assign btn.right_rise    = rise[1];
   assign btn.jump_rise     = rise[2];
   assign btn.dir           = {stab[1] & ~stab[0], stab[0] & ~stab[1]};
   assign btn.charge_active = (state == CHARGING);
   assign btn.jump_charge   = charge;
   assign btn.jump_release  = release_p;
endmodule

// File: tb/tb_btn_input_stage.sv
// Directed bench for btn_input_stage with DEBOUNCE_CYCLES = 4.
// Pad/tick changes and checks happen on the falling clock edge.
module tb_btn_input_stage;
   localparam int CW = 8;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   n_lrise;
   int   n_rrise;
   int   n_rel;
   int   snap;

   btn_input_stage_if #(.CHARGE_WIDTH(CW)) b ();

   btn_input_stage #(
      .DEBOUNCE_CYCLES(4),
      .DB_CNT_WIDTH   (4),
      .CHARGE_WIDTH   (CW),
      .CHARGE_MAX     (60),
      .REPEAT_TICKS   (8)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .btn      (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (b.left_rise) n_lrise++;
      if (b.right_rise) n_rrise++;
      if (b.jump_release) n_rel++;
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_tick();
      b.tick = 1'b1;
      cyc();
      b.tick = 1'b0;
      cyc();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      n_lrise = 0; n_rrise = 0; n_rel = 0;
      rst_n = 1'b0;
      b.left_btn = 1'b0; b.right_btn = 1'b0;
      b.jump_btn = 1'b0; b.tick = 1'b0;
      cyc(); cyc();
      chk("rst_levels", {29'd0, b.jump_level, b.right_level, b.left_level}, 0);
      chk("rst_rises", {29'd0, b.jump_rise, b.right_rise, b.left_rise}, 0);
      chk("rst_dir", 32'(b.dir), 0);
      chk("rst_charge", 32'(b.jump_charge), 0);
      chk("rst_active", 32'(b.charge_active), 0);
      chk("rst_release", 32'(b.jump_release), 0);
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("idle_levels", {29'd0, b.jump_level, b.right_level, b.left_level}, 0);

      // Short glitch on left
      #2 snap = n_lrise;
      b.left_btn = 1'b1;
      repeat (3) cyc();
      b.left_btn = 1'b0;
      repeat (10) cyc();
      chk("glitch_level", 32'(b.left_level), 0);
      #2 chk("glitch_rises", 32'(n_lrise - snap), 0);

      // Left held: level exactly 6 cycles after the pad edge
      snap = n_lrise;
      b.left_btn = 1'b1;
      repeat (5) cyc();
      chk("left_lvl_at5", 32'(b.left_level), 0);
      cyc();
      chk("left_lvl_at6", 32'(b.left_level), 1);
      chk("left_rise_at6", 32'(b.left_rise), 1);
      chk("dir_left", 32'(b.dir), 1);
      cyc();
      chk("left_rise_once", 32'(b.left_rise), 0);
      b.right_btn = 1'b1;
      repeat (6) cyc();
      chk("right_level", 32'(b.right_level), 1);
      chk("dir_both", 32'(b.dir), 0);
      b.left_btn = 1'b0;
      repeat (6) cyc();
      chk("dir_right", 32'(b.dir), 2);
      b.right_btn = 1'b0;
      repeat (6) cyc();
      chk("dir_none", 32'(b.dir), 0);
      #2 chk("left_rise_cnt", 32'(n_lrise - snap), 1);

      // Jump held across 10 ticks; tick lands on the release cycle
      b.jump_btn = 1'b1;
      repeat (6) cyc();
      chk("jump_rise", 32'(b.jump_rise), 1);
      chk("jump_idle_yet", 32'(b.charge_active), 0);
      cyc();
      chk("jump_active", 32'(b.charge_active), 1);
      chk("jump_chg0", 32'(b.jump_charge), 0);
      repeat (10) do_tick();
      chk("jump_chg10", 32'(b.jump_charge), 10);
      #2 snap = n_rel;
      b.jump_btn = 1'b0;
      repeat (6) cyc();
      chk("rel_pulse", 32'(b.jump_release), 1);
      chk("rel_chg", 32'(b.jump_charge), 10);
      b.tick = 1'b1;
      cyc();
      b.tick = 1'b0;
      chk("rel_one_cycle", 32'(b.jump_release), 0);
      chk("rel_no_incr", 32'(b.jump_charge), 10);
      chk("rel_inactive", 32'(b.charge_active), 0);
      repeat (4) cyc();
      chk("hold_chg10", 32'(b.jump_charge), 10);
      #2 chk("rel_cnt1", 32'(n_rel - snap), 1);

      // Next press clears; 100 ticks saturate at 60
      b.jump_btn = 1'b1;
      repeat (7) cyc();
      chk("repress_chg0", 32'(b.jump_charge), 0);
      repeat (100) do_tick();
      chk("sat_chg60", 32'(b.jump_charge), 60);
      chk("sat_active", 32'(b.charge_active), 1);
      #2 snap = n_rel;
      b.jump_btn = 1'b0;
      repeat (6) cyc();
      b.tick = 1'b1;
      chk("sat_rel_pulse", 32'(b.jump_release), 1);
      cyc();
      b.tick = 1'b0;
      chk("sat_rel_chg", 32'(b.jump_charge), 60);
      repeat (3) cyc();
      #2 chk("sat_rel_cnt", 32'(n_rel - snap), 1);

      // Reset in the middle of a charge
      b.jump_btn = 1'b1;
      repeat (7) cyc();
      repeat (5) do_tick();
      chk("mid_chg5", 32'(b.jump_charge), 5);
      #2 snap = n_rel;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_chg", 32'(b.jump_charge), 0);
      chk("mid_rst_act", 32'(b.charge_active), 0);
      b.jump_btn = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
      repeat (10) cyc();
      chk("post_rst_act", 32'(b.charge_active), 0);
      chk("post_rst_chg", 32'(b.jump_charge), 0);
      #2 chk("post_rst_rel", 32'(n_rel - snap), 0);

      // Right held across 20 ticks
      snap = n_rrise;
      b.right_btn = 1'b1;
      repeat (6) cyc();
      chk("right_rise_edge", 32'(b.right_rise), 1);
      repeat (20) do_tick();
      b.right_btn = 1'b0;
      repeat (8) cyc();
`ifdef BTN_AUTO_REPEAT_EN
      #2 chk("right_rise_cnt", 32'(n_rrise - snap), 3);
`else
      #2 chk("right_rise_cnt", 32'(n_rrise - snap), 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
